// File: rtl/key_move_queue_pkg.sv
// rtl/key_move_queue_pkg.sv - move codes, scan codes and held-bit helpers shared with processor
package key_move_queue_pkg;

    typedef enum logic [2:0] {
        MV_NONE  = 3'd0,
        MV_UP    = 3'd1,
        MV_DOWN  = 3'd2,
        MV_LEFT  = 3'd3,
        MV_RIGHT = 3'd4,
        MV_ACT   = 3'd5
    } move_e;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ACT   = 8'h29;

    localparam int HELD_UP    = 0;
    localparam int HELD_DOWN  = 1;
    localparam int HELD_LEFT  = 2;
    localparam int HELD_RIGHT = 3;
    localparam int HELD_ACT   = 4;
    localparam int HELD_W     = 5;

    // Arrows are E0-extended; ACT is the only plain code in the map.
    function automatic move_e decode_key(input logic ext, input logic [7:0] code);
        move_e m;
        m = MV_NONE;
        if (ext) begin
            case (code)
                SC_UP:    m = MV_UP;
                SC_DOWN:  m = MV_DOWN;
                SC_LEFT:  m = MV_LEFT;
                SC_RIGHT: m = MV_RIGHT;
                default:  m = MV_NONE;
            endcase
        end else if (code == SC_ACT) begin
            m = MV_ACT;
        end
        return m;
    endfunction

    function automatic logic [HELD_W-1:0] held_mask(input move_e m);
        logic [HELD_W-1:0] mask;
        mask = '0;
        case (m)
            MV_UP:    mask[HELD_UP]    = 1'b1;
            MV_DOWN:  mask[HELD_DOWN]  = 1'b1;
            MV_LEFT:  mask[HELD_LEFT]  = 1'b1;
            MV_RIGHT: mask[HELD_RIGHT] = 1'b1;
            MV_ACT:   mask[HELD_ACT]   = 1'b1;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/key_move_queue_move_fifo.sv
// rtl/key_move_queue_move_fifo.sv - DEPTH x W show-ahead FIFO with occupancy count
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("move_fifo DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/key_move_queue.sv
// rtl/key_move_queue.sv - PS/2 key events to queued move commands; AUTOREPEAT_EN adds held-key repeat
module key_move_queue
    import key_move_queue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       keycode_ready,
    input  logic [7:0]                 keycode,
    input  logic                       key_ext,
    input  logic                       key_make,
    output logic                       move_valid,
    input  logic                       move_ready,
    output logic [2:0]                 move,
    output logic [4:0]                 held,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    if ((REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
        $error("key_move_queue needs 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic [HELD_W-1:0] held_q, held_d;
    logic              overflow_q, overflow_d;
    move_e             key_code;
    logic [HELD_W-1:0] key_mask;
    logic              key_hit, key_push;
    logic              push, pop, fifo_full;
    logic [2:0]        push_code;

    always_comb begin
        key_code = decode_key(key_ext, keycode);
        key_mask = held_mask(key_code);
        key_hit  = keycode_ready && (key_code != MV_NONE);
        // A make on an already-held key is a typematic repeat from the keyboard.
        key_push = key_hit && key_make && ((held_q & key_mask) == '0);
        held_d   = held_q;
        if (key_hit) begin
            held_d = key_make ? (held_q | key_mask) : (held_q & ~key_mask);
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    move_e         target_q, target_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_active, rpt_fire;

    always_comb begin
        rpt_active = (target_q != MV_NONE) && ((held_q & held_mask(target_q)) != '0);
        rpt_fire   = rpt_active && (rpt_cnt_q == RPT_LAST);
        target_d   = target_q;
        rpt_cnt_d  = '0;
        if (rpt_active) begin
            // Reloading part-way makes later repeats come REPEAT_PERIOD apart.
            rpt_cnt_d = rpt_fire ? RPT_RELOAD : rpt_cnt_q + RW'(1);
        end
        if (key_push && (key_code != MV_ACT)) begin
            target_d  = key_code;
            rpt_cnt_d = '0;
        end else if (key_hit && !key_make && (key_code == target_q)) begin
            target_d  = MV_NONE;
            rpt_cnt_d = '0;
        end
        push      = key_push || rpt_fire;
        push_code = key_push ? key_code : target_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target_q  <= MV_NONE;
            rpt_cnt_q <= '0;
        end else begin
            target_q  <= target_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    always_comb begin
        push      = key_push;
        push_code = key_code;
    end
`endif

    always_comb begin
        pop        = move_valid && move_ready;
        overflow_d = overflow_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    move_fifo #(
        .DEPTH (DEPTH),
        .W     (3)
    ) u_move_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .head      (move),
        .valid     (move_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign held     = held_q;
    assign overflow = overflow_q;

endmodule
